// File: rtl/key_input_ctrl_if.sv
// Raw push-button inputs and the conditioned control outputs of the clock front-end.
interface key_input_ctrl_if;
    logic [3:0] KEY;
    logic       inc;
    logic       inc2;
    logic       sel;
    logic       clr;

    modport master (output KEY, input inc, inc2, sel, clr);
    modport slave  (input KEY, output inc, inc2, sel, clr);
endinterface

// File: rtl/key_input_ctrl.sv
// Push-button conditioner: sync + debounce per key, auto-repeat on inc/inc2,
// toggled select level and long-press clear.
module key_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
    parameter int unsigned CLEAR_HOLD_CYCLES   = 100000000
) (
    input  logic         clk,
    input  logic         res,
    key_input_ctrl_if.slave kif
);
    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned RP_MAX   = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                       REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int DB_W = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int RP_W = (RP_MAX            > 1) ? $clog2(RP_MAX)            : 1;
    localparam int CL_W = (CLEAR_HOLD_CYCLES > 1) ? $clog2(CLEAR_HOLD_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [CL_W-1:0] CL_LAST = CL_W'(CLEAR_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_t;
    typedef enum logic [1:0] {C_IDLE, C_HOLD, C_DONE}    clr_state_t;

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] press;
    logic [1:0]          rep_pulse;
    logic                clr_fire;

    // Released level is 1 everywhere, so a key held through reset re-debounces as a new press.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic            sy1, sy2, stab, stab_d;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (res) begin
                sy1    <= 1'b1;
                sy2    <= 1'b1;
                stab   <= 1'b1;
                stab_d <= 1'b1;
                cnt    <= '0;
            end else begin
                sy1    <= kif.KEY[k];
                sy2    <= sy1;
                stab_d <= stab;
                if (sy2 == stab) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    stab <= sy2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable[k]   = stab;
        assign stable_d[k] = stab_d;
    end

    assign press = stable_d & ~stable;

    // Clear fires this edge; repeat pulses landing on the same edge are masked.
    clr_state_t      cst;
    logic [CL_W-1:0] ctmr;
    logic            clr_q;

    assign clr_fire = (cst == C_HOLD) && !stable[3] && (ctmr == CL_LAST);

    always_ff @(posedge clk) begin
        if (res) begin
            cst   <= C_IDLE;
            ctmr  <= '0;
            clr_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (cst)
                C_IDLE: if (press[3]) begin
                    cst  <= C_HOLD;
                    ctmr <= '0;
                end
                C_HOLD: if (stable[3]) begin
                    cst  <= C_IDLE;
                    ctmr <= '0;
                end else if (ctmr == CL_LAST) begin
                    cst   <= C_DONE;
                    ctmr  <= '0;
                    clr_q <= 1'b1;
                end else begin
                    ctmr <= ctmr + 1'b1;
                end
                C_DONE: if (stable[3]) cst <= C_IDLE;
                default: cst <= C_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_rep
        rep_state_t      st;
        logic [RP_W-1:0] tmr;
        logic            pulse;

        always_ff @(posedge clk) begin
            if (res) begin
                st    <= R_IDLE;
                tmr   <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (st)
                    R_IDLE: if (press[r]) begin
                        pulse <= ~clr_fire;
                        tmr   <= '0;
                        st    <= R_DELAY;
                    end
                    R_DELAY: if (stable[r]) begin
                        st  <= R_IDLE;
                        tmr <= '0;
                    end else if (tmr == RD_LAST) begin
                        pulse <= ~clr_fire;
                        tmr   <= '0;
                        st    <= R_REPEAT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                    R_REPEAT: if (stable[r]) begin
                        st  <= R_IDLE;
                        tmr <= '0;
                    end else if (tmr == RR_LAST) begin
                        pulse <= ~clr_fire;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                    default: st <= R_IDLE;
                endcase
            end
        end

        assign rep_pulse[r] = pulse;
    end

    logic sel_q;
    always_ff @(posedge clk) begin
        if (res)           sel_q <= 1'b0;
        else if (press[2]) sel_q <= ~sel_q;
    end

    assign kif.inc  = rep_pulse[0];
    assign kif.inc2 = rep_pulse[1];
    assign kif.sel  = sel_q;
    assign kif.clr  = clr_q;
endmodule

// File: tb/tb_key_input_ctrl.sv
// Bench for key_input_ctrl: scenario table, hand-written corner sequences and
// randomized key activity checked cycle by cycle against an event-time model.
module tb_key_input_ctrl;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int CH = 30;

    logic clk = 1'b0;
    logic res = 1'b1;
    key_input_ctrl_if kif ();

    key_input_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_RATE_CYCLES(RR), .CLEAR_HOLD_CYCLES(CH)
    ) dut (.clk(clk), .res(res), .kif(kif));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Model: keys as sampled levels, debounced as "D consecutive disagreeing cycles",
    // repeat/clear expressed as edge distances from the press edge.
    logic [3:0] m_s1, m_s2, m_st, m_std;
    int  m_run [4];
    int  m_pe  [2];
    int  m_ce;
    bit  m_sel, e_inc, e_inc2, e_clr;

    int  o_inc, o_inc2, o_sel, o_clr, first_ev, clr_edge, clr_inc;
    bit  prev_sel;

    typedef struct {
        logic [3:0] mask;
        int hold, gap, n_inc, n_inc2, n_sel, n_clr, first;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        logic [3:0] st_b, prs;
        bit p [2];
        int dt;
        if (res) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_st = 4'hF; m_std = 4'hF;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
            m_pe[0] = -1; m_pe[1] = -1; m_ce = -1;
            m_sel = 0; e_inc = 0; e_inc2 = 0; e_clr = 0;
            return;
        end
        st_b = m_st;
        prs  = m_std & ~m_st;
        e_clr = 0;
        if (prs[3]) m_ce = edge_n;
        else if (m_ce >= 0) begin
            if (st_b[3]) m_ce = -1;
            else if (edge_n - m_ce == CH) begin e_clr = 1; m_ce = -1; end
        end
        for (int r = 0; r < 2; r++) begin
            p[r] = 0;
            if (prs[r]) begin m_pe[r] = edge_n; p[r] = 1; end
            else if (m_pe[r] >= 0) begin
                if (st_b[r]) m_pe[r] = -1;
                else begin
                    dt = edge_n - m_pe[r];
                    if (dt == RD || (dt > RD && (dt - RD) % RR == 0)) p[r] = 1;
                end
            end
        end
        e_inc  = p[0] && !e_clr;
        e_inc2 = p[1] && !e_clr;
        if (prs[2]) m_sel = !m_sel;
        for (int k = 0; k < 4; k++) begin
            if (m_s2[k] != m_st[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin m_st[k] = m_s2[k]; m_run[k] = 0; end
            end else m_run[k] = 0;
        end
        m_std = st_b;
        m_s2  = m_s1;
        m_s1  = kif.KEY;
    endtask

    task automatic clear_obs();
        o_inc = 0; o_inc2 = 0; o_sel = 0; o_clr = 0;
        first_ev = -1; clr_edge = -1; clr_inc = -1;
    endtask

    task automatic tick();
        bit sc;
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        chk("inc",  int'(kif.inc),  int'(e_inc));
        chk("inc2", int'(kif.inc2), int'(e_inc2));
        chk("sel",  int'(kif.sel),  int'(m_sel));
        chk("clr",  int'(kif.clr),  int'(e_clr));
        sc = (kif.sel != prev_sel);
        prev_sel = kif.sel;
        o_inc += int'(kif.inc); o_inc2 += int'(kif.inc2);
        o_clr += int'(kif.clr); o_sel += int'(sc);
        if (kif.clr) begin clr_edge = edge_n; clr_inc = int'(kif.inc); end
        if (first_ev < 0 && (kif.inc || kif.inc2 || kif.clr || sc)) first_ev = edge_n;
    endtask

    // Returns E0: the first edge that samples the pressed level.
    task automatic run_press(input logic [3:0] mask, input int hold, input int gap, output int e0);
        clear_obs();
        e0 = edge_n + 1;
        kif.KEY = ~mask;
        repeat (hold) tick();
        kif.KEY = 4'hF;
        repeat (gap) tick();
    endtask

    initial begin
        int e0, rs;
        kif.KEY = 4'hF;
        prev_sel = 0;
        clear_obs();

        //               mask    hold gap inc inc2 sel clr first
        tbl[0]  = '{4'b0001, 10, 15, 1, 0, 0, 0,  6};
        tbl[1]  = '{4'b0001,  3, 15, 0, 0, 0, 0, -1};
        tbl[2]  = '{4'b0001,  4, 15, 1, 0, 0, 0,  6};
        tbl[3]  = '{4'b0001, 60, 15, 6, 0, 0, 0,  6};
        tbl[4]  = '{4'b0010, 30, 15, 0, 3, 0, 0,  6};
        tbl[5]  = '{4'b0011, 30, 15, 3, 3, 0, 0,  6};
        tbl[6]  = '{4'b0100, 10, 15, 0, 0, 1, 0,  6};
        tbl[7]  = '{4'b0100, 40, 15, 0, 0, 1, 0,  6};
        tbl[8]  = '{4'b1000, 20, 15, 0, 0, 0, 0, -1};
        tbl[9]  = '{4'b1000, 50, 15, 0, 0, 0, 1, 36};
        tbl[10] = '{4'b1000, 30, 15, 0, 0, 0, 0, -1};
        tbl[11] = '{4'b1000, 31, 15, 0, 0, 0, 1, 36};

        res = 1'b1;
        repeat (3) tick();
        chk("rst_inc", int'(kif.inc), 0);
        chk("rst_inc2", int'(kif.inc2), 0);
        chk("rst_sel", int'(kif.sel), 0);
        chk("rst_clr", int'(kif.clr), 0);
        res = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 12; i++) begin
            run_press(tbl[i].mask, tbl[i].hold, tbl[i].gap, e0);
            chk($sformatf("v%0d_inc_cnt", i),  o_inc,  tbl[i].n_inc);
            chk($sformatf("v%0d_inc2_cnt", i), o_inc2, tbl[i].n_inc2);
            chk($sformatf("v%0d_sel_cnt", i),  o_sel,  tbl[i].n_sel);
            chk($sformatf("v%0d_clr_cnt", i),  o_clr,  tbl[i].n_clr);
            chk($sformatf("v%0d_first", i), (first_ev < 0) ? -1 : first_ev - e0, tbl[i].first);
        end

        // Bounce on KEY[1]: 2-cycle halves never reach the debounce count.
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            kif.KEY = 4'b1101; repeat (2) tick();
            kif.KEY = 4'b1111; repeat (2) tick();
        end
        repeat (15) tick();
        chk("bounce_inc2", o_inc2, 0);

        // Three select presses: level walks 0->1->0->1.
        for (int i = 0; i < 3; i++) begin
            run_press(4'b0100, 10, 10, e0);
            chk($sformatf("selp%0d_first", i), first_ev - e0, 6);
            chk($sformatf("selp%0d_cnt", i), o_sel, 1);
            chk($sformatf("selp%0d_lvl", i), int'(kif.sel), (i + 1) % 2);
        end

        // Clear with KEY[0] pressed 2 cycles later: inc repeat lands on the clr edge.
        clear_obs();
        e0 = edge_n + 1;
        kif.KEY = 4'b0111; repeat (2) tick();
        kif.KEY = 4'b0110; repeat (48) tick();
        kif.KEY = 4'b1111; repeat (20) tick();
        chk("ovl_clr_cnt", o_clr, 1);
        chk("ovl_clr_at", clr_edge - e0, 36);
        chk("ovl_inc_on_clr", clr_inc, 0);
        chk("ovl_inc_cnt", o_inc, 4);

        // Reset while repeating with the key still held.
        kif.KEY = 4'b1110;
        repeat (40) tick();
        res = 1'b1;
        tick();
        chk("mid_rst_inc", int'(kif.inc), 0);
        chk("mid_rst_sel", int'(kif.sel), 0);
        chk("mid_rst_clr", int'(kif.clr), 0);
        res = 1'b0;
        clear_obs();
        rs = edge_n + 1;
        repeat (20) tick();
        chk("post_rst_first_inc", first_ev - rs, 6);
        kif.KEY = 4'hF;
        repeat (15) tick();

        // Random key activity with bounces and occasional resets.
        for (int it = 0; it < 60; it++) begin
            int hold, gap, rpos;
            logic [3:0] k;
            k    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 70);
            gap  = $urandom_range(0, 20);
            rpos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hold - 1) : -1;
            kif.KEY = ~k;
            for (int c = 0; c < hold; c++) begin
                res = (c == rpos);
                if ($urandom_range(0, 9) == 0) kif.KEY[$urandom_range(0, 3)] ^= 1'b1;
                tick();
            end
            res = 1'b0;
            kif.KEY = 4'hF;
            repeat (gap) tick();
        end
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_input_ctrl.md
# key_input_ctrl

Front-end user-input conditioner for the digital clock: turns the four raw active-low board push-buttons into the clean control signals the counter/display block consumes (`inc`, `inc2`, `sel`, and a clear request). Each key passes through a two-flop synchronizer and a debouncer. `inc` and `inc2` get auto-repeat. `sel` is a toggled mode level. Clear requires a long press. All outputs are synchronous to `clk` and feed the counter block directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000 — cycles a key must stay at a new level before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, default 25000000 — hold time from the accepted press to the first repeat pulse.
- `REPEAT_RATE_CYCLES`, default 5000000 — interval between subsequent repeat pulses.
- `CLEAR_HOLD_CYCLES`, default 100000000 — hold time on KEY[3] before `clr` fires.
- `clk` input 1 — system clock; the single clock of the block.
- `res` input 1 — synchronous, active-high reset.
- `KEY` input 4 — raw asynchronous push-buttons, active-low: [0]=inc, [1]=inc2, [2]=sel, [3]=clear.
- `inc` output 1 — one-cycle pulse per press and per repeat of KEY[0].
- `inc2` output 1 — one-cycle pulse per press and per repeat of KEY[1].
- `sel` output 1 — level that toggles on each accepted press of KEY[2].
- `clr` output 1 — one-cycle pulse once per long hold of KEY[3].

## Operation
- **Synchronizer:** two flops per key, both reset to 1 (released).
- **Debouncer:** each key has a `stable` state, reset to 1, and a counter.
  - The counter increments on every cycle where the synchronized value differs from `stable`.
  - Any cycle where they match clears the counter to 0.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ: `stable` takes the synchronized value and the counter clears.
- **Press and release:** a press event is `stable` going 1→0, detected one cycle later from a registered copy of `stable`. A release event is `stable` going 0→1.
- **Repeat FSM:** KEY[0] and KEY[1] each have an independent FSM with states IDLE, DELAY, REPEAT and a shared-width timer.
  - IDLE: on press, pulse the output, clear the timer, go to DELAY.
  - DELAY: when the timer reaches REPEAT_DELAY_CYCLES-1, pulse, clear the timer, go to REPEAT.
  - REPEAT: every REPEAT_RATE_CYCLES cycles, pulse and clear the timer.
  - DELAY or REPEAT: a release (`stable`==1) returns to IDLE in the same cycle and clears the timer; no pulse on release.
- **Select:** on press of KEY[2], `sel` <= ~`sel`. No repeat; a hold does nothing further.
- **Clear FSM:** states IDLE, HOLD, DONE.
  - IDLE: on press, go to HOLD with the timer cleared.
  - HOLD: when the timer reaches CLEAR_HOLD_CYCLES-1, pulse `clr` and go to DONE.
  - DONE: wait for release, then go to IDLE.
  - A release during HOLD returns to IDLE with no pulse.
- **Simultaneous events:**
  - In any cycle where `clr` pulses, `inc` and `inc2` are forced to 0; their FSMs keep running.
  - `inc` and `inc2` are otherwise independent and may pulse in the same cycle.
  - A `sel` toggle does not affect the other keys.
- **Timer widths:** each timer is $clog2 of its largest compared parameter. Timers never wrap, because every terminal count clears them.
- **Reset mid-operation:** all state returns to reset values and any repeat or clear in progress is abandoned. A key still held after reset deasserts is seen as a new press and goes through full debounce.

## Timing
- **Reset values:** `inc`=0, `inc2`=0, `clr`=0, `sel`=0. All FSMs in IDLE, all counters and timers 0.
- **Press latency:** edge E0 is the first edge at which a low KEY is sampled. `inc`/`inc2` is high for exactly one cycle after edge E0+DEBOUNCE_CYCLES+2. `sel` changes at the same edge.
- **First repeat:** REPEAT_DELAY_CYCLES cycles after the press pulse.
- **Later repeats:** every REPEAT_RATE_CYCLES cycles after that.
- **Clear:** `clr` is high CLEAR_HOLD_CYCLES cycles after the internal press event, i.e. E0+DEBOUNCE_CYCLES+2+CLEAR_HOLD_CYCLES.
- **Glitch rejection:** a bounce shorter than DEBOUNCE_CYCLES consecutive differing cycles produces no event.
- **Pulse width:** every output pulse is exactly one cycle wide. No pulses are generated while `res` is high.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, CLEAR_HOLD_CYCLES=30.
- **Clean press:** KEY[0] low for 10 cycles, then high → `inc` pulses once, exactly 6 edges after E0; no release pulse.
- **Bounce:** KEY[1] toggles low/high every 2 cycles for 20 cycles, then goes high → `inc2` never asserts.
- **Auto-repeat:** KEY[0] held low for 60 cycles → `inc` pulses at cycles 6, 26, 34, 42, 50, 58 relative to E0. Release → no further pulses, FSM back to IDLE.
- **Select toggle:** KEY[2] pressed 3 times, held 10 cycles each, with 10-cycle gaps → `sel` goes 0→1→0→1, each change 6 edges after its E0; no toggling during holds.
- **Clear:**
  - KEY[3] held for 20 cycles → no `clr`.
  - KEY[3] held for 50 cycles → `clr` pulses once at E0+36.
  - KEY[0] held simultaneously so that an `inc` repeat lands on the `clr` cycle → `inc` is 0 in that cycle.
- **Reset mid-repeat:** `res` asserted for 1 cycle during REPEAT with KEY[0] still low → all outputs 0 and `sel`=0. A new `inc` pulse appears 6 edges after reset deasserts.
